// File: rtl/tomasulo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tomasulo_pkg
// Purpose : Opcode encodings, instruction classes and the decoded-entry type.
// Revision: 1.0
// ============================================================================
package tomasulo_pkg;

    localparam int REG_W = 5;
    localparam int OFF_W = 12;

    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_MUL  = 7'b1100011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;

    typedef enum logic [1:0] {
        CLS_ADD  = 2'd0,
        CLS_MUL  = 2'd1,
        CLS_LOAD = 2'd2
    } instr_class_t;

    typedef struct packed {
        logic [6:0]       opcode;
        logic [6:0]       fun7;
        logic [2:0]       fun3;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [OFF_W-1:0] lw_offset;
        instr_class_t     cls;
    } dec_entry_t;

endpackage
`default_nettype wire

// File: rtl/instr_field_decode.sv
`default_nettype none
// ============================================================================
// Module  : instr_field_decode
// Purpose : Combinational split of an RV32 word into dispatch fields + class.
// Revision: 1.0
// ============================================================================
module instr_field_decode
    import tomasulo_pkg::*;
(
    input  logic [31:0] instr,
    output dec_entry_t  entry,
    output logic        illegal
);

    always_comb begin
        entry.opcode    = instr[6:0];
        entry.rd        = instr[11:7];
        entry.fun3      = instr[14:12];
        entry.rs1       = instr[19:15];
        entry.rs2       = instr[24:20];
        entry.fun7      = instr[31:25];
        entry.lw_offset = '0;
        entry.cls       = CLS_ADD;
        illegal         = 1'b0;
        case (instr[6:0])
            OP_ADD:  entry.cls = CLS_ADD;
            OP_MUL:  entry.cls = CLS_MUL;
            OP_LOAD: begin
                // Loads reuse the rs2/fun7 bit positions as the immediate.
                entry.cls       = CLS_LOAD;
                entry.lw_offset = instr[31:20];
                entry.rs2       = '0;
                entry.fun7      = '0;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module  : decode_queue
// Purpose : Decodes fetched words and buffers them in an in-order show-ahead FIFO.
// Revision: 1.0
// ============================================================================
module decode_queue
    import tomasulo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32
) (
    input  logic                     clk1,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     fetch_valid,
    input  logic [31:0]              fetch_instr,
    input  logic [PC_W-1:0]          fetch_pc,
    output logic                     fetch_ready,
    output logic                     dq_valid,
    output logic [6:0]               dq_opcode,
    output logic [6:0]               dq_fun7,
    output logic [2:0]               dq_fun3,
    output logic [REG_W-1:0]         dq_rs1,
    output logic [REG_W-1:0]         dq_rs2,
    output logic [REG_W-1:0]         dq_rd,
    output logic [OFF_W-1:0]         dq_lw_offset,
    output logic [1:0]               dq_class,
    output logic [PC_W-1:0]          dq_pc,
    input  logic                     dis_accept,
    output logic [$clog2(DEPTH):0]   dq_count,
    output logic [7:0]               illegal_cnt
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w+1)'(DEPTH);

    dec_entry_t          r_mem_entry [DEPTH];
    logic [PC_W-1:0]     r_mem_pc    [DEPTH];
    logic [c_ptr_w-1:0]  r_head;
    logic [c_ptr_w-1:0]  r_tail;
    logic [c_ptr_w:0]    r_count;
    logic [7:0]          r_illegal_cnt;

    dec_entry_t          w_dec;
    logic                w_illegal;
    logic                w_take;
    logic                w_enq;
    logic                w_deq;
    dec_entry_t          w_head;
    logic [PC_W-1:0]     w_head_pc;

    instr_field_decode u_decode (
        .instr   (fetch_instr),
        .entry   (w_dec),
        .illegal (w_illegal)
    );

    assign fetch_ready = (r_count < c_depth);
    assign dq_valid    = (r_count != '0);
    assign w_take      = fetch_valid && fetch_ready && !flush;
    assign w_enq       = w_take && !w_illegal;
    assign w_deq       = dq_valid && dis_accept && !flush;

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_illegal_cnt <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + c_ptr_w'(1);
            if (w_deq) r_head <= r_head + c_ptr_w'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + (c_ptr_w+1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_take && w_illegal && (r_illegal_cnt != 8'hFF))
                r_illegal_cnt <= r_illegal_cnt + 8'd1;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk1) begin
        if (w_enq && !rst) begin
            r_mem_entry[r_tail] <= w_dec;
            r_mem_pc[r_tail]    <= fetch_pc;
        end
    end

    assign w_head    = dq_valid ? r_mem_entry[r_head] : '0;
    assign w_head_pc = dq_valid ? r_mem_pc[r_head]    : '0;

    assign dq_opcode    = w_head.opcode;
    assign dq_fun7      = w_head.fun7;
    assign dq_fun3      = w_head.fun3;
    assign dq_rs1       = w_head.rs1;
    assign dq_rs2       = w_head.rs2;
    assign dq_rd        = w_head.rd;
    assign dq_lw_offset = w_head.lw_offset;
    assign dq_class     = w_head.cls;
    assign dq_pc        = w_head_pc;
    assign dq_count     = r_count;
    assign illegal_cnt  = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_decode_queue
// Purpose : Directed table-driven bench for decode_queue.
// Revision: 1.0
// ============================================================================
module tb_decode_queue;

    localparam int DEPTH = 8;
    localparam int PC_W  = 32;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        flush;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        dq_valid;
    logic [6:0]  dq_opcode;
    logic [6:0]  dq_fun7;
    logic [2:0]  dq_fun3;
    logic [4:0]  dq_rs1;
    logic [4:0]  dq_rs2;
    logic [4:0]  dq_rd;
    logic [11:0] dq_lw_offset;
    logic [1:0]  dq_class;
    logic [31:0] dq_pc;
    logic        dis_accept;
    logic [3:0]  dq_count;
    logic [7:0]  illegal_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        legal;
        logic [6:0]  op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] off;
        logic [1:0]  cls;
        logic [7:0]  ill;
    } vec_t;

    vec_t vecs [7];

    always #5 clk1 = ~clk1;

    decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk1         (clk1),
        .rst          (rst),
        .flush        (flush),
        .fetch_valid  (fetch_valid),
        .fetch_instr  (fetch_instr),
        .fetch_pc     (fetch_pc),
        .fetch_ready  (fetch_ready),
        .dq_valid     (dq_valid),
        .dq_opcode    (dq_opcode),
        .dq_fun7      (dq_fun7),
        .dq_fun3      (dq_fun3),
        .dq_rs1       (dq_rs1),
        .dq_rs2       (dq_rs2),
        .dq_rd        (dq_rd),
        .dq_lw_offset (dq_lw_offset),
        .dq_class     (dq_class),
        .dq_pc        (dq_pc),
        .dis_accept   (dis_accept),
        .dq_count     (dq_count),
        .illegal_cnt  (illegal_cnt)
    );

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_head(input string tag, input vec_t v);
        check({tag, " valid"},  64'(dq_valid),     64'(1'b1));
        check({tag, " opcode"}, 64'(dq_opcode),    64'(v.op));
        check({tag, " fun7"},   64'(dq_fun7),      64'(v.f7));
        check({tag, " fun3"},   64'(dq_fun3),      64'(v.f3));
        check({tag, " rs1"},    64'(dq_rs1),       64'(v.rs1));
        check({tag, " rs2"},    64'(dq_rs2),       64'(v.rs2));
        check({tag, " rd"},     64'(dq_rd),        64'(v.rd));
        check({tag, " offset"}, 64'(dq_lw_offset), 64'(v.off));
        check({tag, " class"},  64'(dq_class),     64'(v.cls));
        check({tag, " pc"},     64'(dq_pc),        64'(v.pc));
    endtask

    function automatic logic [31:0] add_word(input int rd);
        logic [31:0] w;
        w = 32'h0000_0033;
        w[11:7] = 5'(rd);
        return w;
    endfunction

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        fetch_instr = instr;
        fetch_pc    = pc;
        fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h002081B3, 32'h0000_0100, 1'b1, 7'b0110011, 7'd0,    3'd0, 5'd1,  5'd2,  5'd3,  12'd0,     2'd0, 8'd0};
        vecs[1] = '{32'h00C32283, 32'h0000_0104, 1'b1, 7'b0000011, 7'd0,    3'd2, 5'd6,  5'd0,  5'd5,  12'd12,    2'd2, 8'd0};
        vecs[2] = '{32'h00000013, 32'h0000_0108, 1'b0, 7'd0,       7'd0,    3'd0, 5'd0,  5'd0,  5'd0,  12'd0,     2'd0, 8'd1};
        vecs[3] = '{32'h40B50463, 32'h0000_010C, 1'b1, 7'b1100011, 7'h20,   3'd0, 5'd10, 5'd11, 5'd8,  12'd0,     2'd1, 8'd1};
        vecs[4] = '{32'hFFFFFFB3, 32'h0000_0110, 1'b1, 7'b0110011, 7'h7F,   3'd7, 5'd31, 5'd31, 5'd31, 12'd0,     2'd0, 8'd1};
        vecs[5] = '{32'h0000007F, 32'h0000_0114, 1'b0, 7'd0,       7'd0,    3'd0, 5'd0,  5'd0,  5'd0,  12'd0,     2'd0, 8'd2};
        vecs[6] = '{32'hFFFFFF83, 32'h0000_0118, 1'b1, 7'b0000011, 7'd0,    3'd7, 5'd31, 5'd0,  5'd31, 12'hFFF,   2'd2, 8'd2};

        rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; dis_accept = 1'b0;
        fetch_instr = '0; fetch_pc = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset valid",   64'(dq_valid),    64'(1'b0));
        check("reset count",   64'(dq_count),    64'(0));
        check("reset ready",   64'(fetch_ready), 64'(1'b1));
        check("reset illegal", 64'(illegal_cnt), 64'(0));
        check("reset opcode",  64'(dq_opcode),   64'(0));
        check("reset pc",      64'(dq_pc),       64'(0));

        // ADD head must hold while dispatch stalls.
        push(vecs[0].instr, vecs[0].pc);
        for (int c = 0; c < 5; c++) begin
            check_head("hold", vecs[0]);
            check("hold count", 64'(dq_count), 64'(1));
            tick();
        end
        dis_accept = 1'b1; tick(); dis_accept = 1'b0;
        check("hold drained", 64'(dq_count), 64'(0));

        for (int i = 0; i < 7; i++) begin
            push(vecs[i].instr, vecs[i].pc);
            check($sformatf("vec%0d illegal_cnt", i), 64'(illegal_cnt), 64'(vecs[i].ill));
            if (vecs[i].legal) begin
                check_head($sformatf("vec%0d", i), vecs[i]);
                dis_accept = 1'b1; tick(); dis_accept = 1'b0;
            end else begin
                check($sformatf("vec%0d dropped valid", i), 64'(dq_valid), 64'(1'b0));
                check($sformatf("vec%0d dropped rd", i),    64'(dq_rd),    64'(0));
            end
            check($sformatf("vec%0d count after", i), 64'(dq_count), 64'(0));
        end

        // Fill to full, then hold a ninth word against backpressure.
        for (int k = 0; k < 8; k++) push(add_word(k), 32'(k * 4));
        check("full count", 64'(dq_count),    64'(8));
        check("full ready", 64'(fetch_ready), 64'(1'b0));
        fetch_instr = add_word(8); fetch_pc = 32'd32; fetch_valid = 1'b1;
        tick();
        check("full hold count", 64'(dq_count), 64'(8));
        check("full hold head",  64'(dq_rd),    64'(0));
        dis_accept = 1'b1; tick(); dis_accept = 1'b0;
        check("after pop count", 64'(dq_count),    64'(7));
        check("after pop ready", 64'(fetch_ready), 64'(1'b1));
        tick();
        fetch_valid = 1'b0;
        check("ninth taken count", 64'(dq_count), 64'(8));
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("order rd %0d", k), 64'(dq_rd), 64'(k));
            check($sformatf("order pc %0d", k), 64'(dq_pc), 64'(k * 4));
            dis_accept = 1'b1; tick(); dis_accept = 1'b0;
        end
        check("drained count", 64'(dq_count), 64'(0));

        // Continuous streaming through the wrap point.
        dis_accept = 1'b1;
        fetch_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            fetch_instr = add_word(k);
            fetch_pc    = 32'h1000 + 32'(k * 4);
            tick();
            check($sformatf("stream count %0d", k), 64'(dq_count), 64'(1));
            check($sformatf("stream pc %0d", k),    64'(dq_pc),    64'(32'h1000 + 32'(k * 4)));
        end
        fetch_valid = 1'b0;
        tick();
        dis_accept = 1'b0;
        check("stream end count", 64'(dq_count), 64'(0));

        // Flush beats concurrent enqueue/dequeue and keeps the drop counter.
        for (int k = 0; k < 4; k++) push(add_word(k), 32'(k * 4));
        check("pre-flush count", 64'(dq_count), 64'(4));
        fetch_instr = add_word(9); fetch_pc = 32'h9999;
        fetch_valid = 1'b1; dis_accept = 1'b1; flush = 1'b1;
        tick();
        fetch_valid = 1'b0; dis_accept = 1'b0; flush = 1'b0;
        check("flush count",   64'(dq_count),    64'(0));
        check("flush valid",   64'(dq_valid),    64'(1'b0));
        check("flush illegal", 64'(illegal_cnt), 64'(2));
        check("flush pc",      64'(dq_pc),       64'(0));
        push(add_word(7), 32'h2000);
        check("post-flush pc",    64'(dq_pc),    64'(32'h2000));
        check("post-flush count", 64'(dq_count), 64'(1));
        dis_accept = 1'b1; tick(); dis_accept = 1'b0;

        // Drop counter saturates.
        fetch_instr = 32'h00000013; fetch_valid = 1'b1;
        for (int k = 0; k < 300; k++) tick();
        fetch_valid = 1'b0;
        check("saturate illegal", 64'(illegal_cnt), 64'(255));
        check("saturate valid",   64'(dq_valid),    64'(1'b0));

        // Reset mid-operation clears everything including the drop counter.
        for (int k = 0; k < 4; k++) push(add_word(k), 32'(k * 4));
        check("pre-reset count", 64'(dq_count), 64'(4));
        fetch_instr = add_word(9); fetch_valid = 1'b1; dis_accept = 1'b1; rst = 1'b1;
        tick();
        fetch_valid = 1'b0; dis_accept = 1'b0; rst = 1'b0;
        check("rst count",   64'(dq_count),    64'(0));
        check("rst valid",   64'(dq_valid),    64'(1'b0));
        check("rst illegal", 64'(illegal_cnt), 64'(0));
        check("rst ready",   64'(fetch_ready), 64'(1'b1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Decode-and-buffer stage directly upstream of the dispatch stage.
- Accepts raw 32-bit RV32 instruction words from fetch, splits them into the fields dispatch consumes (opcode, fun7, fun3, rs1, rs2, rd, lw_offset), and holds them in an in-order FIFO.
- Presents the head entry to dispatch. Holds it stable until dispatch signals acceptance (its issue flag) because ROB or reservation-station space was free.

Parameters:
DEPTH, 8, number of queue entries; power of two, >=2
PC_W, 32, width of carried program counter

Ports:
clk1  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous queue clear (mispredict/recovery)
fetch_valid  input  1  fetch_instr/fetch_pc valid this cycle
fetch_instr  input  32  raw instruction word
fetch_pc  input  PC_W  instruction address
fetch_ready  output  1  queue can accept this cycle
dq_valid  output  1  head entry valid
dq_opcode  output  7  head opcode
dq_fun7  output  7  head fun7
dq_fun3  output  3  head fun3
dq_rs1  output  5  head rs1
dq_rs2  output  5  head rs2
dq_rd  output  5  head rd
dq_lw_offset  output  12  head load offset
dq_class  output  2  0=ADD, 1=MUL, 2=LOAD
dq_pc  output  PC_W  head PC
dis_accept  input  1  dispatch consumed head this cycle
dq_count  output  $clog2(DEPTH)+1  occupancy
illegal_cnt  output  8  dropped-instruction counter, saturating

Behaviour:
- Clock and reset: one clock, clk1. rst is synchronous and active-high.
- Reset: count, head pointer and tail pointer = 0; illegal_cnt = 0; dq_valid = 0.
- Empty queue: all dq_* field outputs drive 0.
- fetch_ready = (count < DEPTH), combinational from count. No same-cycle pass-through when full: at count == DEPTH, fetch_ready = 0 even if dis_accept = 1.
- Enqueue when fetch_valid && fetch_ready, on the rising edge. The entry is visible at the head no earlier than the next cycle (1-cycle latency when the queue was empty).
- Field extraction:
  - opcode = [6:0], rd = [11:7], fun3 = [14:12], rs1 = [19:15], rs2 = [24:20], fun7 = [31:25].
  - LOAD class: lw_offset = [31:20], rs2 = 0, fun7 = 0.
  - Other classes: lw_offset = 0.
- Class mapping:
  - 0110011 -> ADD.
  - 1100011 -> MUL (this is the design's multiply encoding).
  - 0000011 -> LOAD.
- Any other opcode is illegal:
  - fetch_ready still honoured.
  - Word is discarded with no entry written.
  - illegal_cnt increments, saturating at 255.
- Dequeue: dis_accept is ignored when dq_valid = 0. When dq_valid && dis_accept, the head advances on the edge. Head outputs are show-ahead (combinational read of the head storage) and stay stable while dis_accept = 0.
- Simultaneous enqueue and dequeue (0 < count < DEPTH): count unchanged; both pointers advance.
- Pointers wrap modulo DEPTH. Count is tracked explicitly, so full and empty are unambiguous.
- flush:
  - Next cycle: count = 0, pointers = 0, dq_valid = 0.
  - Same-cycle enqueue and dequeue are ignored.
  - illegal_cnt is preserved.
- Priority: rst > flush > enqueue/dequeue.
- Reset mid-operation discards all contents; the queue is empty the following cycle.

Decomposition:
- Shared package tomasulo_pkg holds:
  - OP_ADD = 7'b0110011, OP_MUL = 7'b1100011, OP_LOAD = 7'b0000011.
  - Class enum (CLS_ADD, CLS_MUL, CLS_LOAD).
  - Register-index width 5 and offset width 12.
  - The decoded-entry struct.
- One sub-module, instr_field_decode: purely combinational word -> decoded entry + illegal flag. It is reusable by the bench's reference model.

Test Plan:
- Decode ADD: reset, then enqueue 0x002081B3 with dis_accept = 0 -> next cycle dq_valid = 1, opcode 0110011, rs1 = 1, rs2 = 2, rd = 3, fun3 = 0, fun7 = 0, class 0, lw_offset 0; outputs hold for 5 cycles.
- Decode LOAD: enqueue 0x00C32283 -> rd = 5, rs1 = 6, rs2 = 0, fun3 = 010, lw_offset = 12, class 2.
- Drop illegal: enqueue 0x00000013 -> no entry, dq_valid stays 0, illegal_cnt = 1; 300 such words -> illegal_cnt = 255.
- Fill and backpressure: 8 legal words with dis_accept = 0 -> dq_count = 8, fetch_ready = 0; a 9th word held on fetch_valid is not taken; raise dis_accept for one cycle -> count 7, fetch_ready = 1, 9th word accepted next cycle, order preserved.
- Wrap-around: 20 words streamed with dis_accept = 1 continuously -> all 20 exit in order with correct PCs; count never exceeds 1 once streaming starts.
- Flush and reset: with 4 entries queued, pulse flush together with fetch_valid and dis_accept -> next cycle count = 0, dq_valid = 0, illegal_cnt unchanged; repeat using rst -> illegal_cnt = 0.
